ec_point_unit: RTL

//  Affine elliptic-curve point unit over GF(p) for the ECDSA scalar-multiply datapath: P+Q or 2P on y^2=x^3+ax+b.

---
 rtl/ec_point_unit_pkg.sv | 32 +++
 rtl/ec_point_unit_arith.sv | 179 +++++++++++++++++
 rtl/ec_point_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ec_point_unit_pkg.sv
// Shared types for the affine elliptic-curve point unit: controller states,
// field-arithmetic opcodes and the operation-mode encoding.
package ec_point_unit_pkg;

    // Point-unit controller states. The arithmetic states each run a short
    // sequence of field operations on the shared arithmetic sub-unit.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_TRIV,
        ST_NUM,
        ST_DEN,
        ST_INV,
        ST_LAM,
        ST_X3,
        ST_Y3,
        ST_DONE
    } state_t;

    // Field-arithmetic opcodes understood by mod_arith_unit.
    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_INV
    } alu_op_t;

    // Value of the mode input.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_DBL = 1'b1;

endpackage

// File: rtl/ec_point_unit_arith.sv
// Shared GF(p) arithmetic sub-unit. Add/sub finish one cycle after start,
// multiply is an MSB-first interleaved shift-add-reduce taking exactly N
// cycles, and inversion is a binary extended Euclid that folds the
// subtract-and-halve into one step so it never needs more than 2N steps.
module mod_arith_unit
    import ec_point_unit_pkg::*;
#(
    parameter int N = 256
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  alu_op_t       i_op,
    input  logic [N-1:0]  i_a,
    input  logic [N-1:0]  i_b,
    input  logic [N-1:0]  i_p,
    output logic          o_done,
    output logic [N-1:0]  o_result
);

    localparam int CW = $clog2(2 * N + 2) + 1;
    localparam logic [CW-1:0] INV_LIMIT = CW'(2 * N);
    localparam logic [N-1:0]  ONE       = N'(1);

    logic          r_busy;
    alu_op_t       r_op;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_p;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_ma;
    logic [N-1:0]  r_mb;
    logic [N-1:0]  r_u;
    logic [N-1:0]  r_v;
    logic [N-1:0]  r_x1;
    logic [N-1:0]  r_x2;
    logic [N-1:0]  r_result;
    logic          r_done;

    logic [N-1:0]  w_accDbl;
    logic [N-1:0]  w_accNext;
    logic [N-1:0]  w_uNext;
    logic [N-1:0]  w_vNext;
    logic [N-1:0]  w_x1Next;
    logic [N-1:0]  w_x2Next;
    logic          w_invStop;

    function automatic logic [N-1:0] fAdd(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic [N-1:0] m);
        logic [N:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[N-1:0];
    endfunction

    function automatic logic [N-1:0] fSub(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic [N-1:0] m);
        logic [N-1:0] d;
        d = x - y;
        if (x < y) d = d + m;
        return d;
    endfunction

    // Halving mod an odd m: odd values borrow one m to become even first.
    function automatic logic [N-1:0] fHalf(input logic [N-1:0] x, input logic [N-1:0] m);
        logic [N:0] s;
        s = {1'b0, x};
        if (x[0]) s = s + {1'b0, m};
        return s[N:1];
    endfunction

    // One multiply step: acc = 2*acc (+ multiplicand when the current bit is set).
    always_comb begin
        w_accDbl  = fAdd(r_acc, r_acc, r_p);
        w_accNext = w_accDbl;
        if (r_mb[N-1]) w_accNext = fAdd(w_accDbl, r_ma, r_p);
    end

    // One inversion step keeping x1*a == u and x2*a == v (mod p).
    always_comb begin
        w_uNext  = r_u;
        w_vNext  = r_v;
        w_x1Next = r_x1;
        w_x2Next = r_x2;
        if (!r_u[0]) begin
            w_uNext  = r_u >> 1;
            w_x1Next = fHalf(r_x1, r_p);
        end else if (!r_v[0]) begin
            w_vNext  = r_v >> 1;
            w_x2Next = fHalf(r_x2, r_p);
        end else if (r_u >= r_v) begin
            w_uNext  = (r_u - r_v) >> 1;
            w_x1Next = fHalf(fSub(r_x1, r_x2, r_p), r_p);
        end else begin
            w_vNext  = (r_v - r_u) >> 1;
            w_x2Next = fHalf(fSub(r_x2, r_x1, r_p), r_p);
        end
    end

    // Zero operands and the step limit stop the loop so bad inputs cannot hang it.
    assign w_invStop = (r_u == ONE) || (r_v == ONE) || (r_u == '0) || (r_v == '0) ||
                       (r_cnt == INV_LIMIT);

    // Operation sequencing: latch operands on start, iterate while busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy   <= 1'b0;
            r_op     <= OP_ADD;
            r_cnt    <= '0;
            r_p      <= '0;
            r_acc    <= '0;
            r_ma     <= '0;
            r_mb     <= '0;
            r_u      <= '0;
            r_v      <= '0;
            r_x1     <= '0;
            r_x2     <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (i_start) begin
                    r_op <= i_op;
                    r_p  <= i_p;
                    unique case (i_op)
                        OP_ADD: begin
                            r_result <= fAdd(i_a, i_b, i_p);
                            r_done   <= 1'b1;
                        end
                        OP_SUB: begin
                            r_result <= fSub(i_a, i_b, i_p);
                            r_done   <= 1'b1;
                        end
                        OP_MUL: begin
                            r_busy <= 1'b1;
                            r_acc  <= '0;
                            r_ma   <= i_a;
                            r_mb   <= i_b;
                            r_cnt  <= CW'(N);
                        end
                        OP_INV: begin
                            r_busy <= 1'b1;
                            r_u    <= i_a;
                            r_v    <= i_p;
                            r_x1   <= ONE;
                            r_x2   <= '0;
                            r_cnt  <= '0;
                        end
                    endcase
                end
            end else if (r_op == OP_MUL) begin
                r_acc <= w_accNext;
                r_mb  <= r_mb << 1;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_result <= w_accNext;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
            end else begin
                if (w_invStop) begin
                    r_result <= (r_u == ONE) ? r_x1 : r_x2;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end else begin
                    r_u   <= w_uNext;
                    r_v   <= w_vNext;
                    r_x1  <= w_x1Next;
                    r_x2  <= w_x2Next;
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: rtl/ec_point_unit.sv
// Affine point add / double over GF(p) on y^2 = x^3 + ax + b. The controller
// resolves special cases in CHECK, otherwise computes lambda and the result
// coordinates as a fixed sequence of operations on one mod_arith_unit.
module ec_point_unit
    import ec_point_unit_pkg::*;
#(
    parameter int N = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [N-1:0]  p,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  x1,
    input  logic [N-1:0]  y1,
    input  logic          inf1,
    input  logic [N-1:0]  x2,
    input  logic [N-1:0]  y2,
    input  logic          inf2,
    output logic          ready,
    output logic          done,
    output logic [N-1:0]  x3,
    output logic [N-1:0]  y3,
    output logic          infinity
);

    state_t        r_state;
    logic [1:0]    r_step;
    logic          r_wait;
    logic          r_mode;
    logic          r_dbl;
    logic [N-1:0]  r_p, r_a, r_x1, r_y1, r_x2, r_y2;
    logic          r_inf1, r_inf2;
    logic [N-1:0]  r_tNum, r_tDen, r_lam, r_t, r_x3t;
    logic [N-1:0]  r_trivX, r_trivY;
    logic          r_trivInf;
    logic          r_ready, r_done, r_inf;
    logic [N-1:0]  r_x3, r_y3;

    alu_op_t       w_aluOp;
    logic [N-1:0]  w_aluA, w_aluB, w_aluResult;
    logic          w_aluStart, w_aluDone, w_arith, w_lastStep;

    mod_arith_unit #(.N(N)) u_arith (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_start  (w_aluStart),
        .i_op     (w_aluOp),
        .i_a      (w_aluA),
        .i_b      (w_aluB),
        .i_p      (r_p),
        .o_done   (w_aluDone),
        .o_result (w_aluResult)
    );

    // Operand selection for the field operation belonging to the current state/step.
    always_comb begin
        w_aluOp    = OP_ADD;
        w_aluA     = '0;
        w_aluB     = '0;
        w_lastStep = 1'b1;
        w_arith    = 1'b1;
        unique case (r_state)
            ST_NUM: begin
                if (!r_dbl) begin
                    w_aluOp = OP_SUB; w_aluA = r_y2; w_aluB = r_y1;
                end else begin
                    w_lastStep = (r_step == 2'd3);
                    unique case (r_step)
                        2'd0:    begin w_aluOp = OP_MUL; w_aluA = r_x1;   w_aluB = r_x1; end
                        2'd1:    begin w_aluOp = OP_ADD; w_aluA = r_t;    w_aluB = r_t;  end
                        2'd2:    begin w_aluOp = OP_ADD; w_aluA = r_tNum; w_aluB = r_t;  end
                        default: begin w_aluOp = OP_ADD; w_aluA = r_tNum; w_aluB = r_a;  end
                    endcase
                end
            end
            ST_DEN: begin
                if (r_dbl) begin
                    w_aluOp = OP_ADD; w_aluA = r_y1; w_aluB = r_y1;
                end else begin
                    w_aluOp = OP_SUB; w_aluA = r_x2; w_aluB = r_x1;
                end
            end
            ST_INV: begin
                w_aluOp = OP_INV; w_aluA = r_tDen;
            end
            ST_LAM: begin
                w_aluOp = OP_MUL; w_aluA = r_tNum; w_aluB = r_tDen;
            end
            ST_X3: begin
                w_lastStep = (r_step == 2'd2);
                unique case (r_step)
                    2'd0:    begin w_aluOp = OP_MUL; w_aluA = r_lam; w_aluB = r_lam; end
                    2'd1:    begin w_aluOp = OP_SUB; w_aluA = r_t;   w_aluB = r_x1;  end
                    default: begin w_aluOp = OP_SUB; w_aluA = r_t;   w_aluB = r_dbl ? r_x1 : r_x2; end
                endcase
            end
            ST_Y3: begin
                w_lastStep = (r_step == 2'd2);
                unique case (r_step)
                    2'd0:    begin w_aluOp = OP_SUB; w_aluA = r_x1;  w_aluB = r_x3t; end
                    2'd1:    begin w_aluOp = OP_MUL; w_aluA = r_lam; w_aluB = r_t;   end
                    default: begin w_aluOp = OP_SUB; w_aluA = r_t;   w_aluB = r_y1;  end
                endcase
            end
            default: w_arith = 1'b0;
        endcase
    end

    assign w_aluStart = w_arith && !r_wait;

    // Point-unit controller with registered handshake and result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_step    <= 2'd0;
            r_wait    <= 1'b0;
            r_mode    <= MODE_ADD;
            r_dbl     <= 1'b0;
            r_p       <= '0;
            r_a       <= '0;
            r_x1      <= '0;
            r_y1      <= '0;
            r_x2      <= '0;
            r_y2      <= '0;
            r_inf1    <= 1'b0;
            r_inf2    <= 1'b0;
            r_tNum    <= '0;
            r_tDen    <= '0;
            r_lam     <= '0;
            r_t       <= '0;
            r_x3t     <= '0;
            r_trivX   <= '0;
            r_trivY   <= '0;
            r_trivInf <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_inf     <= 1'b0;
            r_x3      <= '0;
            r_y3      <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_p     <= p;
                        r_a     <= a;
                        r_x1    <= x1;
                        r_y1    <= y1;
                        r_inf1  <= inf1;
                        r_x2    <= x2;
                        r_y2    <= y2;
                        r_inf2  <= inf2;
                        r_dbl   <= 1'b0;
                        r_step  <= 2'd0;
                        r_wait  <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= ST_CHECK;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    r_trivX   <= '0;
                    r_trivY   <= '0;
                    r_trivInf <= 1'b0;
                    r_state   <= ST_TRIV;
                    if (r_mode == MODE_DBL) begin
                        if (r_inf1 || (r_y1 == '0)) begin
                            r_trivInf <= 1'b1;
                        end else begin
                            r_dbl   <= 1'b1;
                            r_state <= ST_NUM;
                        end
                    end else if (r_inf1) begin
                        r_trivX   <= r_inf2 ? '0 : r_x2;
                        r_trivY   <= r_inf2 ? '0 : r_y2;
                        r_trivInf <= r_inf2;
                    end else if (r_inf2) begin
                        r_trivX <= r_x1;
                        r_trivY <= r_y1;
                    end else if ((r_x1 == r_x2) && (r_y1 != r_y2)) begin
                        r_trivInf <= 1'b1;
                    end else if (r_x1 == r_x2) begin
                        r_dbl   <= 1'b1;
                        r_state <= ST_NUM;
                    end else begin
                        r_state <= ST_NUM;
                    end
                end
                ST_TRIV: begin
                    r_x3    <= r_trivX;
                    r_y3    <= r_trivY;
                    r_inf   <= r_trivInf;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: begin
                    if (!r_wait) begin
                        r_wait <= 1'b1;
                    end else if (w_aluDone) begin
                        r_wait <= 1'b0;
                        r_step <= w_lastStep ? 2'd0 : r_step + 2'd1;
                        unique case (r_state)
                            ST_NUM: begin
                                if (r_dbl && (r_step == 2'd0)) r_t <= w_aluResult;
                                else                           r_tNum <= w_aluResult;
                                if (w_lastStep) r_state <= ST_DEN;
                            end
                            ST_DEN: begin
                                r_tDen  <= w_aluResult;
                                r_state <= ST_INV;
                            end
                            ST_INV: begin
                                r_tDen  <= w_aluResult;
                                r_state <= ST_LAM;
                            end
                            ST_LAM: begin
                                r_lam   <= w_aluResult;
                                r_state <= ST_X3;
                            end
                            ST_X3: begin
                                if (w_lastStep) begin
                                    r_x3t   <= w_aluResult;
                                    r_state <= ST_Y3;
                                end else begin
                                    r_t <= w_aluResult;
                                end
                            end
                            default: begin
                                if (w_lastStep) begin
                                    r_x3    <= r_x3t;
                                    r_y3    <= w_aluResult;
                                    r_inf   <= 1'b0;
                                    r_done  <= 1'b1;
                                    r_ready <= 1'b1;
                                    r_state <= ST_DONE;
                                end else begin
                                    r_t <= w_aluResult;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign done     = r_done;
    assign x3       = r_x3;
    assign y3       = r_y3;
    assign infinity = r_inf;

endmodule
